pr_elastic: RTL and testbench

Parametrised elastic pipeline register for the out-of-order core. It replaces the fixed stall/flush stage registers with a DEPTH-deep chain of valid/ready stages carrying a WIDTH-bit payload plus an active-list tag. It supports bubble collapsing, full flush and selective (age-based) squash of entries younger than a mispredicted branch. It sits between any two pipeline stages, for example decode→issue or issue→execute.

---
 rtl/pr_pkg.sv | 22 ++
 rtl/pr_skid_buffer.sv | 80 ++++++++
 rtl/pr_elastic.sv | 128 ++++++++++++
 tb/tb_pr_elastic.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// Shared defaults and the wrap-safe age comparison for the pr_elastic pipeline register.
package pr_pkg;

   localparam int PR_WIDTH_DEF = 64;
   localparam int PR_DEPTH_DEF = 2;
   localparam int PR_TAG_W_DEF = 6;

   // Ages are distances from the active-list head, so the compare survives id wrap (tag_w <= 32).
   function automatic logic pr_younger(input logic [31:0] tag,
                                       input logic [31:0] ref_tag,
                                       input logic [31:0] head,
                                       input int          tag_w);
      logic [31:0] mask;
      logic [31:0] age_a;
      logic [31:0] age_b;
      mask  = (tag_w >= 32) ? '1 : ((32'd1 << tag_w) - 32'd1);
      age_a = (tag - head) & mask;
      age_b = (ref_tag - head) & mask;
      return age_a > age_b;
   endfunction

endpackage

// File: rtl/pr_skid_buffer.sv
// Two-entry skid buffer ahead of stage 0 with a registered up_ready; exists only when PR_SKID_EN is defined.
`ifdef PR_SKID_EN
module pr_skid_buffer
   import pr_pkg::*;
#(
   parameter int WIDTH = PR_WIDTH_DEF,
   parameter int TAG_W = PR_TAG_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   input  logic [TAG_W-1:0] up_tag,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_data,
   output logic [TAG_W-1:0] dn_tag,
   input  logic             flush,
   input  logic             squash_valid,
   input  logic [TAG_W-1:0] squash_tag,
   input  logic [TAG_W-1:0] al_head,
   output logic [1:0]       cnt_next
);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] data;
   } pr_entry_t;

   pr_entry_t s0_q, s1_q, s0_d, s1_d, in_e;
   logic      keep0, keep1, take, bypass;

   function automatic logic is_killed(input logic [TAG_W-1:0] t);
      return flush | (squash_valid & pr_younger(32'(t), 32'(squash_tag), 32'(al_head), TAG_W));
   endfunction

   // Slots stay compacted (s1 valid implies s0 valid), so a full buffer is just s1 valid.
   assign up_ready = ~s1_q.valid;
   assign dn_valid = s0_q.valid | up_valid;
   assign dn_data  = s0_q.valid ? s0_q.data : up_data;
   assign dn_tag   = s0_q.valid ? s0_q.tag  : up_tag;
   assign in_e     = '{valid: 1'b1, tag: up_tag, data: up_data};

   always_comb begin
      bypass = ~s0_q.valid & dn_ready;
      keep0  = s0_q.valid & ~dn_ready & ~is_killed(s0_q.tag);
      keep1  = s1_q.valid & ~is_killed(s1_q.tag);
      take   = up_valid & up_ready & ~bypass & ~is_killed(up_tag);
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      s0_d       = s0_q;
      s1_d       = s1_q;
      s0_d.valid = 1'b0;
      s1_d.valid = 1'b0;
      if (keep0) begin
         s0_d = s0_q;
         if (keep1)     s1_d = s1_q;
         else if (take) s1_d = in_e;
      end else if (keep1) begin
         s0_d = s1_q;
         if (take) s1_d = in_e;
      end else if (take) begin
         s0_d = in_e;
      end
      cnt_next = {1'b0, s0_d.valid} + {1'b0, s1_d.valid};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q <= '0;
         s1_q <= '0;
      end else begin
         s0_q <= s0_d;
         s1_q <= s1_d;
      end
   end

endmodule
`endif

// File: rtl/pr_elastic.sv
// DEPTH-deep elastic valid/ready register with bubble collapsing, flush and age-based squash.
// Define PR_SKID_EN to add a 2-entry skid buffer that registers in_ready.
module pr_elastic
   import pr_pkg::*;
#(
   parameter int WIDTH = PR_WIDTH_DEF,
   parameter int DEPTH = PR_DEPTH_DEF,
   parameter int TAG_W = PR_TAG_W_DEF,
`ifdef PR_SKID_EN
   localparam int CAP = DEPTH + 2,
`else
   localparam int CAP = DEPTH,
`endif
   localparam int OCC_W = $clog2(CAP + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flush,
   input  logic             squash_valid,
   input  logic [TAG_W-1:0] squash_tag,
   input  logic [TAG_W-1:0] al_head,
   output logic [OCC_W-1:0] occupancy
);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] data;
   } pr_entry_t;

   pr_entry_t        stg_q [DEPTH];
   pr_entry_t        stg_d [DEPTH];
   pr_entry_t        src   [DEPTH];
   pr_entry_t        fe_e;
   logic [DEPTH-1:0] load;
   logic             fe_valid;
   logic [WIDTH-1:0] fe_data;
   logic [TAG_W-1:0] fe_tag;
   logic [1:0]       skid_cnt_d;
   logic [OCC_W-1:0] occ_d, occ_q;

   function automatic logic is_killed(input logic [TAG_W-1:0] t);
      return flush | (squash_valid & pr_younger(32'(t), 32'(squash_tag), 32'(al_head), TAG_W));
   endfunction

`ifdef PR_SKID_EN
   pr_skid_buffer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_skid (
      .clk          (clk),
      .rst          (rst),
      .up_valid     (in_valid),
      .up_ready     (in_ready),
      .up_data      (in_data),
      .up_tag       (in_tag),
      .dn_valid     (fe_valid),
      .dn_ready     (load[0]),
      .dn_data      (fe_data),
      .dn_tag       (fe_tag),
      .flush        (flush),
      .squash_valid (squash_valid),
      .squash_tag   (squash_tag),
      .al_head      (al_head),
      .cnt_next     (skid_cnt_d)
   );
`else
   assign fe_valid   = in_valid;
   assign fe_data    = in_data;
   assign fe_tag     = in_tag;
   assign in_ready   = load[0];
   assign skid_cnt_d = 2'd0;
`endif

   assign fe_e = '{valid: fe_valid, tag: fe_tag, data: fe_data};

   // A stage loads when it is empty or its successor takes its entry; this collapses bubbles.
   always_comb begin
      logic chain;
      chain = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         chain   = ~stg_q[k].valid | chain;
         load[k] = chain;
      end
   end

   always_comb begin
      src[0] = fe_e;
      for (int k = 1; k < DEPTH; k++) src[k] = stg_q[k-1];
      occ_d = OCC_W'(skid_cnt_d);
      for (int k = 0; k < DEPTH; k++) begin
         stg_d[k] = stg_q[k];
         if (load[k]) begin
            stg_d[k].valid = src[k].valid & ~is_killed(src[k].tag);
            if (src[k].valid) begin
               stg_d[k].tag  = src[k].tag;
               stg_d[k].data = src[k].data;
            end
         end else begin
            stg_d[k].valid = stg_q[k].valid & ~is_killed(stg_q[k].tag);
         end
         occ_d = occ_d + OCC_W'(stg_d[k].valid);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload is reset along with valid so out_data/out_tag read 0 out of reset.
         stg_q <= '{default: '0};
         occ_q <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
         stg_q <= stg_d;
         occ_q <= occ_d;
      end
   end

   assign out_valid = stg_q[DEPTH-1].valid & ~is_killed(stg_q[DEPTH-1].tag);
   assign out_data  = stg_q[DEPTH-1].data;
   assign out_tag   = stg_q[DEPTH-1].tag;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pr_elastic.sv
// Scoreboard bench for pr_elastic: an in-order list of live beats, pruned by the age/kill rule.
module tb_pr_elastic;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;
   localparam int TAG_W = 3;
`ifdef PR_SKID_EN
   localparam int CAP = DEPTH + 2;
`else
   localparam int CAP = DEPTH;
`endif
   localparam int OCC_W = $clog2(CAP + 1);

   logic             clk, rst;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, out_data;
   logic [TAG_W-1:0] in_tag, out_tag, squash_tag, al_head;
   logic             flush, squash_valid;
   logic [OCC_W-1:0] occupancy;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_keep[$];
   beat_t mon_b;
   int    n_cmp  = 0;
   int    n_fail = 0;
   bit    mon_en = 0;

   pr_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_tag      (out_tag),
      .flush        (flush),
      .squash_valid (squash_valid),
      .squash_tag   (squash_tag),
      .al_head      (al_head),
      .occupancy    (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Age = distance from the head modulo 2^TAG_W.
   function automatic bit ref_younger(input int a, input int b, input int h);
      int m;
      m = 1 << TAG_W;
      return ((a - h + m) % m) > ((b - h + m) % m);
   endfunction

   function automatic bit ref_killed(input int t);
      return flush || (squash_valid && ref_younger(t, int'(squash_tag), int'(al_head)));
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            exp_q.delete();
         end else begin
            check("occupancy", 64'(occupancy), 64'(exp_q.size()));
`ifndef PR_SKID_EN
            check("in_ready", 64'(in_ready), 64'((exp_q.size() < DEPTH) || out_ready));
`endif
            if (flush) check("out_valid_on_flush", 64'(out_valid), 64'(0));
            mon_keep.delete();
            foreach (exp_q[i]) if (!ref_killed(int'(exp_q[i].tag))) mon_keep.push_back(exp_q[i]);
            exp_q = mon_keep;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 64'(out_valid), 64'(0));
               end else begin
                  mon_b = exp_q.pop_front();
                  check("out_tag", 64'(out_tag), 64'(mon_b.tag));
                  check("out_data", 64'(out_data), 64'(mon_b.data));
               end
            end
            if (in_valid && in_ready && !ref_killed(int'(in_tag)))
               exp_q.push_back('{in_tag, in_data});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; squash_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input int tag, input int data);
      in_valid = 1'b1;
      in_tag   = TAG_W'(tag);
      in_data  = WIDTH'(data);
      step();
   endtask

   initial begin
      logic [15:0] ov_seen, ov_exp;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; squash_valid = 1'b0;
      squash_tag = '0; al_head = '0; in_tag = '0; in_data = '0;
      mon_en = 1'b1;
      #7;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_occupancy", 64'(occupancy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      #5 rst = 1'b0;
      step();

      // Streaming: tags 0..9 back to back, first beat visible DEPTH cycles after acceptance.
      ov_seen = '0;
      ov_exp  = '0;
      for (int i = 0; i < 14; i++) begin
         in_valid = (i < 10);
         in_tag   = TAG_W'(i);
         in_data  = WIDTH'(16'hA000 + i);
         ov_exp[i] = (i >= DEPTH) && (i < DEPTH + 10);
         @(negedge clk);
         ov_seen[i] = out_valid;
         step();
      end
      check("stream_out_valid_pattern", 64'(ov_seen), 64'(ov_exp));
      drain(CAP + 4);

      // Back-pressure: fill to capacity, then hold.
      out_ready = 1'b0;
      for (int i = 0; i < CAP; i++) send(i, 16'hB000 + i);
      in_valid = 1'b1; in_tag = TAG_W'(CAP); in_data = 16'hBEEF;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_occupancy", 64'(occupancy), 64'(CAP));
         check("bp_out_tag", 64'(out_tag), 64'(0));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
`ifndef PR_SKID_EN
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'(1));
`endif
      drain(CAP + 4);

      // Wrap-around squash: head 6, held tags 7 (older) and 1, branch tag 0.
      al_head = TAG_W'(6); out_ready = 1'b0;
      send(7, 16'hC007);
      send(1, 16'hC001);
      in_valid = 1'b1; in_tag = TAG_W'(2); in_data = 16'hC002;
      out_ready = 1'b1; squash_valid = 1'b1; squash_tag = TAG_W'(0);
      @(negedge clk);
      check("wrap_in_ready", 64'(in_ready), 64'(1));
      check("wrap_out_valid", 64'(out_valid), 64'(1));
      check("wrap_out_tag", 64'(out_tag), 64'(7));
      step();
      in_valid = 1'b0; squash_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("wrap_occupancy", 64'(occupancy), 64'(0));
      step();

      // Flush beats a simultaneous squash whose tag would spare both entries.
      al_head = '0;
      send(3, 16'hD003);
      send(4, 16'hD004);
      in_valid = 1'b0; flush = 1'b1; squash_valid = 1'b1; squash_tag = TAG_W'(5);
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'(0));
      step();
      flush = 1'b0; squash_valid = 1'b0;
      @(negedge clk);
      check("flush_occupancy", 64'(occupancy), 64'(0));
      drain(CAP + 4);

      // Random traffic with back-pressure, squashes, flushes and head movement.
      for (int c = 0; c < 600; c++) begin
         in_valid     = ($urandom_range(0, 9) < 7);
         in_tag       = TAG_W'($urandom);
         in_data      = WIDTH'($urandom);
         out_ready    = ($urandom_range(0, 9) < 6);
         squash_valid = ($urandom_range(0, 19) == 0);
         squash_tag   = TAG_W'($urandom);
         flush        = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0) al_head = TAG_W'($urandom);
         step();
      end
      drain(CAP + 4);

      // Asynchronous reset pulse between edges while streaming.
      for (int i = 0; i < 5; i++) send(i, 16'hE000 + i);
      #2;
      check("pre_rst_out_valid", 64'(out_valid), 64'(1));
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("rst_pulse_out_valid", 64'(out_valid), 64'(0));
      check("rst_pulse_occupancy", 64'(occupancy), 64'(0));
      @(negedge clk);
      #2 rst = 1'b0;
      drain(CAP + 6);

      check("drain_all_delivered", 64'(exp_q.size()), 64'(0));
      check("drain_occupancy", 64'(occupancy), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
